dsp_mac_result_collector: RTL
=============================

Name: dsp_mac_result_collector

Overview:
Downstream stage of the DSP48E2 multiply-add slice (P = A*B + C, registered A/B, M and P stages).
- Tracks an input-valid token through the DSP's fixed pipeline latency.
- Captures the 48-bit P result into a small FIFO when the token emerges.
- Scales and narrows the result, then presents it on a valid/ready output stream.
- Credit-based backpressure on the operand side ensures no result is ever dropped, because the DSP itself cannot stall.

Parameters:
- LATENCY, 3: DSP register stages from operand ports to P (A/B reg, M reg, P reg); legal 1..8.
- DEPTH, 8: result FIFO entries; power of two, 4..64.
- OUT_W, 32: output result width; legal 8..48.
- OUT_SHIFT, 0: arithmetic right shift applied to P before narrowing; legal 0..47.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- IN_VALID  in  1  operands on DSP A/B/C ports this cycle are a real transaction.
- IN_READY  out  1  collector can accept an operand transaction this cycle.
- P  in  48  DSP P output, signed.
- OUT_VALID  out  1  OUT_DATA holds a result.
- OUT_READY  in  1  consumer accepts OUT_DATA.
- OUT_DATA  out  OUT_W  scaled, narrowed signed result.
- OUT_OVF  out  1  OUT_DATA result was clipped or wrapped during narrowing.
- RESULT_CNT  out  16  count of results delivered (OUT_VALID & OUT_READY); wraps 0xFFFF -> 0.

Behaviour:
- Reset, asynchronous on RST_N low:
  - Valid pipe is cleared; FIFO is emptied (pointers 0, count 0); in-flight count is 0; RESULT_CNT is 0.
  - Outputs: IN_READY=0 while RST_N is low, OUT_VALID=0, OUT_DATA=0, OUT_OVF=0.
  - On the first edge after release, IN_READY=1.
- Reset mid-operation discards all in-flight tokens and FIFO contents; no partial output.
- Accept: a transaction is accepted at edge k iff IN_VALID & IN_READY. IN_VALID with IN_READY=0 is ignored; upstream must hold operands and IN_VALID until accepted.
- Valid pipe: LATENCY-stage shift register.
  - pipe[0] <= accepted; pipe[i] <= pipe[i-1].
  - pipe[LATENCY-1] high means P holds that transaction's result.
  - FIFO write occurs at the following edge, so an operand accepted at edge k is written at edge k+LATENCY.
- In-flight count = popcount of the valid pipe, maintained incrementally.
- IN_READY = (fifo_count + inflight + accepted_this_cycle_pending) < DEPTH, registered.
  - Guarantees a free FIFO slot for every in-flight token; FIFO overflow is impossible and is covered by an assertion.
- Narrowing, computed on write:
  - s = P >>> OUT_SHIFT (sign-extending).
  - OUT_DATA = s[OUT_W-1:0].
  - OUT_OVF = 1 if s does not fit in signed OUT_W (behaviour per Optional Feature).
  - Data and flag are stored together in the FIFO.
- Output:
  - First-word-fall-through; OUT_VALID = fifo not empty.
  - Pop on OUT_VALID & OUT_READY.
  - OUT_DATA/OUT_OVF are stable while OUT_VALID=1 and OUT_READY=0.
  - OUT_DATA reads 0 when empty.
- Simultaneous write and pop: count unchanged. Write and pop on an empty FIFO is not possible (fall-through data appears the cycle after the write).
- Full FIFO with OUT_READY=0 indefinitely: IN_READY stays 0 and the pipe drains into the reserved slots.
- Minimum result latency: accept edge k -> OUT_VALID high after edge k+LATENCY.
- Throughput: one result per cycle sustained when OUT_READY=1.
- Pointers wrap modulo DEPTH.

Optional Feature:
- Macro: DSP_COLLECT_SAT_EN.
- Defined: out-of-range s saturates to the signed OUT_W maximum or minimum, and OUT_OVF=1.
- Undefined: s is truncated (wraps), and OUT_OVF still flags the wrap.
- Interface is identical in both builds.

Decomposition:
- Shared package dsp_collect_pkg holds:
  - P_W=48 and RESULT_CNT_W=16;
  - typedef result_t (OUT_W data + ovf bit);
  - function narrow_result(s) implementing the shift/saturate/truncate rule.
- One sub-module: dsp_collect_fifo, a synchronous FWFT FIFO with count output. The top holds the valid pipe, credit logic and counter.

Test Plan:
- A=2, B=3, C=1 held one cycle with IN_VALID at edge k, DSP model latency 3: OUT_VALID at edge k+3, OUT_DATA=7, OUT_OVF=0, RESULT_CNT 0->1 on pop.
- Back-to-back operand pairs (100,10,5), (0,999,123), (2,3,1) with OUT_READY=1: OUT_DATA sequence 1005, 123, 7 on consecutive cycles, with no bubbles.
- OUT_READY=0, IN_VALID=1 continuous, DEPTH=8: exactly 8 transactions accepted; IN_READY falls once the 8 are in flight or queued; no writes lost; releasing OUT_READY drains 8 in order.
- OUT_SHIFT=0, OUT_W=32, P=2^40:
  - with DSP_COLLECT_SAT_EN: OUT_DATA=0x7FFFFFFF, OUT_OVF=1;
  - without: OUT_DATA=0x00000000, OUT_OVF=1.
- OUT_SHIFT=4, P=-256: OUT_DATA=-16, OUT_OVF=0.
- RST_N pulsed low with 2 in flight and 3 queued: OUT_VALID=0 immediately; after release there is no stale output, RESULT_CNT=0 and IN_READY=1.

Source files
------------

// File: rtl/dsp_collect_pkg.sv
// rtl/dsp_collect_pkg.sv - shared widths, result record and narrowing rule (DSP_COLLECT_SAT_EN selects saturation)
package dsp_collect_pkg;

  localparam int P_W          = 48;
  localparam int RESULT_CNT_W = 16;

  // Data is carried at full P width; the collector keeps only its OUT_W low bits.
  typedef struct packed {
    logic           ovf;
    logic [P_W-1:0] data;
  } result_t;

  // Shift P right arithmetically, then saturate or wrap into a signed out_w-bit field.
  function automatic result_t narrow_result(input logic signed [P_W-1:0] p,
                                            input int                    shift,
                                            input int                    out_w);
    logic signed [P_W-1:0] s;
    logic signed [P_W-1:0] max_v;
    logic signed [P_W-1:0] min_v;
    result_t               r;
    s = p >>> shift;
    if (out_w >= P_W) begin
      max_v = {1'b0, {(P_W-1){1'b1}}};
    end else begin
      max_v = (48'sd1 <<< (out_w - 1)) - 48'sd1;
    end
    min_v = ~max_v;
    r.ovf = (s > max_v) || (s < min_v);
`ifdef DSP_COLLECT_SAT_EN
    if (s > max_v) begin
      r.data = max_v;
    end else if (s < min_v) begin
      r.data = min_v;
    end else begin
      r.data = s;
    end
`else
    r.data = s;
`endif
    return r;
  endfunction

endpackage

// File: rtl/dsp_collect_fifo.sv
// rtl/dsp_collect_fifo.sv - first-word-fall-through result FIFO with occupancy count
module dsp_collect_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [W-1:0]     wr_data_i,
  input  logic             rd_en_i,
  output logic [W-1:0]     rd_data_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rd_fire;

  assign empty_o   = (count_q == '0);
  assign rd_fire   = rd_en_i & ~empty_o;
  assign count_o   = count_q;
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy next state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_en_i);
    rd_ptr_d = rd_ptr_q + AW'(rd_fire);
    count_d  = count_q + CNT_W'(wr_en_i) - CNT_W'(rd_fire);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because reads are gated by empty.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Upstream credit accounting must never let a write land on a full FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_ni && wr_en_i && !rd_fire) begin
      assert (count_q != CNT_W'(DEPTH));
    end
  end

endmodule

// File: rtl/dsp_mac_result_collector.sv
// rtl/dsp_mac_result_collector.sv - DSP valid-token tracker, credit gate and scaled result stream (DSP_COLLECT_SAT_EN: saturate)
module dsp_mac_result_collector
  import dsp_collect_pkg::*;
#(
  parameter int LATENCY   = 3,
  parameter int DEPTH     = 8,
  parameter int OUT_W     = 32,
  parameter int OUT_SHIFT = 0
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  input  logic [P_W-1:0]          P,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic [OUT_W-1:0]        OUT_DATA,
  output logic                    OUT_OVF,
  output logic [RESULT_CNT_W-1:0] RESULT_CNT
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [LATENCY-1:0]      pipe_q, pipe_d;
  logic [CNT_W-1:0]        inflight_q, inflight_d;
  logic                    in_ready_q, in_ready_d;
  logic [RESULT_CNT_W-1:0] result_cnt_q, result_cnt_d;
  logic [CNT_W:0]          credit_sum;
  logic [CNT_W-1:0]        fifo_count;
  logic                    fifo_empty;
  logic                    accepted;
  logic                    retire;
  logic                    pop;
  result_t                 narrowed;
  logic [OUT_W:0]          wr_data;
  logic [OUT_W:0]          rd_data;

  assign accepted   = IN_VALID & in_ready_q;
  assign retire     = pipe_q[LATENCY-1];
  assign pop        = OUT_VALID & OUT_READY;
  assign IN_READY   = in_ready_q;
  assign OUT_VALID  = ~fifo_empty;
  assign OUT_DATA   = rd_data[OUT_W-1:0];
  assign OUT_OVF    = rd_data[OUT_W];
  assign RESULT_CNT = result_cnt_q;

  assign narrowed = narrow_result(P, OUT_SHIFT, OUT_W);
  assign wr_data  = {narrowed.ovf, narrowed.data[OUT_W-1:0]};

  generate
    if (OUT_W < P_W) begin : g_drop_high
      logic unused_high;
      assign unused_high = ^narrowed.data[P_W-1:OUT_W];
    end
  endgenerate

  // Token pipe, in-flight count, credit gate and delivered-result counter.
  always_comb begin
    pipe_d       = pipe_q << 1;
    pipe_d[0]    = accepted;
    inflight_d   = inflight_q + CNT_W'(accepted) - CNT_W'(retire);
    // Every queued or in-flight token, plus one entering now, owns a FIFO slot.
    credit_sum   = {1'b0, fifo_count} + {1'b0, inflight_q} + (CNT_W + 1)'(accepted);
    in_ready_d   = credit_sum < (CNT_W + 1)'(DEPTH);
    result_cnt_d = result_cnt_q + RESULT_CNT_W'(pop);
  end

  // Control state registers; reset drops all tokens and withholds credit.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pipe_q       <= '0;
      inflight_q   <= '0;
      in_ready_q   <= 1'b0;
      result_cnt_q <= '0;
    end else begin
      pipe_q       <= pipe_d;
      inflight_q   <= inflight_d;
      in_ready_q   <= in_ready_d;
      result_cnt_q <= result_cnt_d;
    end
  end

  dsp_collect_fifo #(
    .W     (OUT_W + 1),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i     (CLK),
    .rst_ni    (RST_N),
    .wr_en_i   (retire),
    .wr_data_i (wr_data),
    .rd_en_i   (pop),
    .rd_data_o (rd_data),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

endmodule
